// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared owner encoding and defaults for the data-memory arbiter
package dmem_arb_pkg;

   // Who drove the RAM in a given cycle; IO_RD/IO_WR tell the return path
   // whether read data is owed to the I/O port one cycle later.
   typedef enum logic [1:0] {
      NONE  = 2'd0,
      PROC  = 2'd1,
      IO_RD = 2'd2,
      IO_WR = 2'd3
   } owner_t;

   // Consecutive denied I/O cycles tolerated before the processor is stalled.
   localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// rtl/dmem_arbiter_starve_counter.sv - saturating wait counter that forces an I/O slot
module starve_counter #(
   parameter int MAX_WAIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic io_req,
   input  logic io_gnt,
   output logic force_io
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;

   // Count cycles an I/O request has been pending without a grant, saturating at the limit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt <= 4'd0;
      end else if (!io_req || io_gnt) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt != WAIT_LIMIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   assign force_io = io_req && (wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM arbiter, processor priority with bounded I/O wait
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_wren,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_data,
   output logic [DATA_W-1:0] p_q,
   output logic              p_stall,
   input  logic              io_req,
   input  logic              io_wren,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_data,
   output logic              io_gnt,
   output logic              io_valid,
   output logic [DATA_W-1:0] io_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wEn,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut
);

   logic   force_io;
   logic   io_own;
   owner_t prev_owner;

   starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .io_req   (io_req),
      .io_gnt   (io_gnt),
      .force_io (force_io)
   );

   // I/O takes the RAM when the processor is idle or when it has waited too long.
   assign io_own  = io_req && (!p_req || force_io);
   assign io_gnt  = io_own;
   assign p_stall = io_own && p_req;

   // The idle case still presents the processor address, just without a write.
   assign ram_addr   = io_own ? io_addr : p_addr;
   assign ram_dataIn = io_own ? io_data : p_data;
   assign ram_wEn    = !reset && (io_own ? io_wren : (p_wren && p_req));

   // Remember this cycle's owner so the read return can be steered next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_owner <= NONE;
      end else if (io_own) begin
         prev_owner <= io_wren ? IO_WR : IO_RD;
      end else if (p_req) begin
         prev_owner <= PROC;
      end else begin
         prev_owner <= NONE;
      end
   end

   assign io_valid = (prev_owner == IO_RD);
   assign io_q     = ram_dataOut;
   assign p_q      = ram_dataOut;

endmodule
